// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, FIFO depth and entry type for the writeback arbiter
package wb_pkg;

  localparam int unsigned WbAddrWidth = 5;
  localparam int unsigned WbDataWidth = 32;
  localparam int unsigned WbFifoDepth = 4;

  typedef struct packed {
    logic [WbAddrWidth-1:0] rd;
    logic [WbDataWidth-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - ALU/MDU result, register-file write and scoreboard signals (WB_SCOREBOARD_EN)
interface writeback_arbiter_if import wb_pkg::*; #(
  parameter int unsigned AddrWidth = WbAddrWidth,
  parameter int unsigned DataWidth = WbDataWidth
);

  logic                 alu_valid;
  logic [AddrWidth-1:0] alu_rd;
  logic [DataWidth-1:0] alu_data;
  logic                 alu_stall;

  logic                 mdu_valid;
  logic                 mdu_ready;
  logic [AddrWidth-1:0] mdu_rd;
  logic [DataWidth-1:0] mdu_data;

  logic                 write_enable;
  logic [AddrWidth-1:0] write_address;
  logic [DataWidth-1:0] write_data;

`ifdef WB_SCOREBOARD_EN
  logic                      issue_valid;
  logic [AddrWidth-1:0]      issue_rd;
  logic [2**AddrWidth-1:0]   busy;
`endif

  modport slave (
`ifdef WB_SCOREBOARD_EN
    input  issue_valid,
    input  issue_rd,
    output busy,
`endif
    input  alu_valid,
    input  alu_rd,
    input  alu_data,
    output alu_stall,
    input  mdu_valid,
    output mdu_ready,
    input  mdu_rd,
    input  mdu_data,
    output write_enable,
    output write_address,
    output write_data
  );

  modport master (
`ifdef WB_SCOREBOARD_EN
    output issue_valid,
    output issue_rd,
    input  busy,
`endif
    output alu_valid,
    output alu_rd,
    output alu_data,
    input  alu_stall,
    output mdu_valid,
    input  mdu_ready,
    output mdu_rd,
    output mdu_data,
    input  write_enable,
    input  write_address,
    input  write_data
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order result FIFO with registered count, async active-low reset
module wb_fifo import wb_pkg::*; #(
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned Depth   = WbFifoDepth,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  entry_t          entry_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and buffered MDU results onto the register-file write port
// Optional pending-destination scoreboard: WB_SCOREBOARD_EN.
module writeback_arbiter import wb_pkg::*; #(
  parameter int unsigned AddrWidth = WbAddrWidth,
  parameter int unsigned DataWidth = WbDataWidth,
  parameter int unsigned FifoDepth = WbFifoDepth
) (
  input logic                clk,
  input logic                rst_n,
  writeback_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  typedef struct packed {
    logic [AddrWidth-1:0] rd;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t               push_entry, head_entry, sel_entry;
  logic                 fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_push, take_fifo, take_alu;

  logic                 we_d, we_q;
  logic [AddrWidth-1:0] wa_d, wa_q;
  logic [DataWidth-1:0] wd_d, wd_q;

  assign push_entry = '{rd: bus.mdu_rd, data: bus.mdu_data};

  // Both handshake outputs depend on the registered count only.
  assign bus.mdu_ready = (fifo_count != CntW'(FifoDepth));
  assign bus.alu_stall = (fifo_count == CntW'(FifoDepth));
  assign fifo_push     = bus.mdu_valid && bus.mdu_ready;

  wb_fifo #(
    .entry_t (entry_t),
    .Depth   (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .entry_i (push_entry),
    .pop_i   (take_fifo),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    take_fifo = 1'b0;
    take_alu  = 1'b0;
    sel_entry = head_entry;
    if (fifo_full) begin
      take_fifo = 1'b1;
    end else if (bus.alu_valid) begin
      take_alu  = 1'b1;
      sel_entry = '{rd: bus.alu_rd, data: bus.alu_data};
    end else if (!fifo_empty) begin
      take_fifo = 1'b1;
    end
  end

  // rd==0 is consumed like any other entry but never raises write_enable.
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (take_alu || take_fifo) begin
      we_d = (sel_entry.rd != '0);
      wa_d = sel_entry.rd;
      wd_d = sel_entry.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;

`ifdef WB_SCOREBOARD_EN
  localparam int unsigned NumRegs = 2**AddrWidth;

  logic [NumRegs-1:0] busy_d, busy_q;

  // Set is applied after clear so a same-cycle re-issue keeps the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (take_fifo && (head_entry.rd != '0)) busy_d[head_entry.rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.busy = busy_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  writeback_arbiter_if #(.AddrWidth(5), .DataWidth(32)) bus ();

  writeback_arbiter #(
    .AddrWidth (5),
    .DataWidth (32),
    .FifoDepth (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_data   = '0;
    bus.mdu_valid  = 1'b0;
    bus.mdu_rd     = '0;
    bus.mdu_data   = '0;
`ifdef WB_SCOREBOARD_EN
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
`endif

    tick();
    chk("rst_we", bus.write_enable, 1'b0);
    chk("rst_addr", bus.write_address, 5'd0);
    chk("rst_data", bus.write_data, 32'h0);
    chk("rst_ready", bus.mdu_ready, 1'b1);
    chk("rst_stall", bus.alu_stall, 1'b0);
    tick();
    rst_n = 1'b1;

    // ALU only
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    chk("alu_we", bus.write_enable, 1'b1);
    chk("alu_addr", bus.write_address, 5'd5);
    chk("alu_data", bus.write_data, 32'hDEADBEEF);
    bus.alu_valid = 1'b0;
    tick();
    chk("alu_we_drop", bus.write_enable, 1'b0);
    chk("alu_addr_hold", bus.write_address, 5'd5);

    // ALU beats a non-full FIFO
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
    tick();
    chk("arb_w1", bus.write_address, 5'd1);
    bus.mdu_valid = 1'b0;
    bus.alu_rd = 5'd2; bus.alu_data = 32'hA2;
    tick();
    chk("arb_w2", bus.write_address, 5'd2);
    bus.alu_rd = 5'd3; bus.alu_data = 32'hA3;
    tick();
    chk("arb_w3", bus.write_address, 5'd3);
    chk("arb_w3_data", bus.write_data, 32'hA3);
    bus.alu_valid = 1'b0;
    tick();
    chk("arb_w7_we", bus.write_enable, 1'b1);
    chk("arb_w7", bus.write_address, 5'd7);
    chk("arb_w7_data", bus.write_data, 32'h11);
    tick();
    chk("arb_idle", bus.write_enable, 1'b0);

    // Fill the FIFO while the ALU keeps winning
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h100;
    bus.mdu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mdu_rd = 5'(11 + i); bus.mdu_data = 32'h200 + 32'(i);
      tick();
      chk("fill_alu", bus.write_address, 5'd10);
    end
    chk("full_ready", bus.mdu_ready, 1'b0);
    chk("full_stall", bus.alu_stall, 1'b1);
    chk("full_count", dut.fifo_count, 3'd4);
    bus.mdu_rd = 5'd15; bus.mdu_data = 32'h215;
    tick();
    chk("full_pop11", bus.write_address, 5'd11);
    chk("full_pop11_d", bus.write_data, 32'h200);
    chk("full_ready2", bus.mdu_ready, 1'b1);
    bus.alu_valid = 1'b0;
    tick();
    chk("full_pop12", bus.write_address, 5'd12);
    bus.mdu_valid = 1'b0;
    tick();
    chk("full_pop13", bus.write_address, 5'd13);
    tick();
    chk("full_pop14", bus.write_address, 5'd14);
    tick();
    chk("full_pop15", bus.write_address, 5'd15);
    chk("full_pop15_d", bus.write_data, 32'h215);
    bus.alu_valid = 1'b1;
    tick();
    chk("alu_resume", bus.write_address, 5'd10);
    bus.alu_valid = 1'b0;
    tick();
    chk("drain_we", bus.write_enable, 1'b0);
    chk("drain_count", dut.fifo_count, 3'd0);

    // rd == 0 from both sources
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    tick();
    chk("rd0_alu_we", bus.write_enable, 1'b0);
    chk("rd0_alu_addr", bus.write_address, 5'd0);
    chk("rd0_alu_data", bus.write_data, 32'h55);
    bus.alu_valid = 1'b0;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h66;
    tick();
    chk("rd0_push_cnt", dut.fifo_count, 3'd1);
    bus.mdu_valid = 1'b0;
    tick();
    chk("rd0_fifo_we", bus.write_enable, 1'b0);
    chk("rd0_fifo_data", bus.write_data, 32'h66);
    chk("rd0_fifo_cnt", dut.fifo_count, 3'd0);

    // Reset with three entries queued
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    bus.mdu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.mdu_rd = 5'(20 + i); bus.mdu_data = 32'h300 + 32'(i);
      tick();
    end
    chk("pre_rst_cnt", dut.fifo_count, 3'd3);
    chk("pre_rst_we", bus.write_enable, 1'b1);
    bus.alu_valid = 1'b0; bus.mdu_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", bus.write_enable, 1'b0);
    chk("mid_rst_ready", bus.mdu_ready, 1'b1);
    chk("mid_rst_cnt", dut.fifo_count, 3'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", bus.write_enable, 1'b0);
    end

`ifdef WB_SCOREBOARD_EN
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    chk("sb_set", bus.busy, 32'h0000_0200);
    bus.issue_valid = 1'b0;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h99;
    tick();
    chk("sb_hold", bus.busy, 32'h0000_0200);
    bus.mdu_valid = 1'b0;
    tick();
    chk("sb_clr_we", bus.write_address, 5'd9);
    chk("sb_clr", bus.busy, 32'h0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h9A;
    tick();
    bus.mdu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    chk("sb_setwins_d", bus.write_data, 32'h9A);
    chk("sb_setwins", bus.busy, 32'h0000_0200);
    bus.issue_rd = 5'd0;
    tick();
    chk("sb_r0", bus.busy, 32'h0000_0200);
    bus.issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("sb_rst", bus.busy, 32'h0);
    tick();
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that sits directly upstream of the register file and drives its single write port (write_enable / write_address / write_data). It merges a single-cycle ALU result path with a long-latency multiply/divide result path. Long-latency results are buffered in a small FIFO, and a pending-destination scoreboard lets decode stall on outstanding long-latency writes.

## Interface
Parameters:
- AddrWidth, 5, register address width (matches the register file)
- DataWidth, 32, data width
- FifoDepth, 4, long-latency result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  AddrWidth  ALU destination register
- alu_data  in  DataWidth  ALU result
- alu_stall  out  1  ALU path must hold; high when FIFO count == FifoDepth
- mdu_valid  in  1  long-latency result offered
- mdu_ready  out  1  FIFO can accept; high when count < FifoDepth
- mdu_rd  in  AddrWidth  long-latency destination register
- mdu_data  in  DataWidth  long-latency result
- write_enable  out  1  to register file
- write_address  out  AddrWidth  to register file
- write_data  out  DataWidth  to register file
- issue_valid  in  1  (WB_SCOREBOARD_EN only) long-latency op issued
- issue_rd  in  AddrWidth  (WB_SCOREBOARD_EN only) its destination
- busy  out  2**AddrWidth  (WB_SCOREBOARD_EN only) per-register pending bit

## Operation
- Push: mdu_valid && mdu_ready enqueues {mdu_rd, mdu_data}.
- Arbitration, evaluated each cycle:
  - FIFO full: FIFO head wins, alu_stall=1, and alu_valid is ignored.
  - Otherwise, alu_valid wins.
  - Otherwise, a non-empty FIFO pops its head.
  - Otherwise, no write.
- Selected source is registered onto write_*.
- rd == 0: the entry is consumed (FIFO pops, ALU accepted) but write_enable stays 0. write_address/write_data still update.
- Simultaneous push and pop: count unchanged. A push into a full FIFO with a simultaneous pop is not allowed; mdu_ready is based on registered count only.
- FIFO ordering is strict in-order. Pointers wrap modulo FifoDepth; count is $clog2(FifoDepth)+1 bits.
- Reset mid-operation: all FIFO contents are discarded and the scoreboard is cleared. No write is emitted after reset assertion.

## Timing
- Reset values: write_enable=0, write_address=0, write_data=0, count=0, pointers=0, busy=0. Derived outputs: mdu_ready=1, alu_stall=0.
- Latency: a source accepted in cycle N appears on write_* in cycle N+1. write_enable is high for exactly one cycle per non-zero-rd accept.
- FIFO pass-through minimum is 2 cycles (push at N, pop at N+1, write at N+2). There is no push-to-pop bypass.
- alu_stall and mdu_ready are combinational from registered count only. There is no combinational path from any *_valid input.
- Throughput: one register write per cycle.

## Configuration
- WB_SCOREBOARD_EN defined:
  - issue_valid && issue_rd != 0 sets busy[issue_rd] on the next edge.
  - A FIFO pop with rd != 0 clears busy[rd] on the same edge that loads write_*.
  - If set and clear target the same rd in the same cycle, set wins.
  - ALU writes never touch busy. busy[0] is always 0.
- WB_SCOREBOARD_EN undefined: the issue_* and busy ports and all scoreboard logic are absent. The rest of the behaviour is identical.

## Structure
- Shared package wb_pkg holds:
  - address and data width constants (5, 32)
  - wb_entry_t packed struct {rd, data}
  - the default FIFO depth constant
- One sub-module, wb_fifo: parameterised synchronous FIFO storing wb_entry_t, with push/pop/full/empty/count and async active-low reset. Arbitration, the output register and the scoreboard stay in writeback_arbiter.

## Test plan
- Reset behaviour: assert rst_n=0 mid-stream with 3 entries queued → write_enable=0, mdu_ready=1, busy=0 immediately. After release, no stale writes appear.
- ALU only: alu_valid with rd=5, data=0xDEADBEEF at cycle N → write_enable=1, address 5, data 0xDEADBEEF at N+1, then 0 at N+2.
- Arbitration: push mdu rd=7 data=0x11, with ALU active for 3 cycles (rd=1,2,3) → writes to 1, 2, 3, then 7. FIFO ordering is preserved.
- FIFO full: push 4 entries with ALU continuously valid → mdu_ready=0 and alu_stall=1. All 4 FIFO entries are written in order before the ALU resumes, and no push is lost.
- rd=0: ALU rd=0 and FIFO entry rd=0 → no write_enable pulse, but the FIFO count decrements.
- Scoreboard (WB_SCOREBOARD_EN):
  - issue rd=9 → busy[9]=1 next cycle.
  - mdu result rd=9 written → busy[9]=0 on the write cycle.
  - Re-issue rd=9 in the same cycle as the pop → busy[9] stays 1.
